// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA raster timing generator.
//   - vga_phase_t : per-axis raster phase (ACTIVE -> FRONT -> SYNC -> BACK).
//   - DEF_*       : default 640x480@60 timing (pixel clocks / lines) and the
//                   default coordinate counter width.
//   - axis_total  : sum of the four phase lengths of one axis.
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Wide enough for 800-1 and 525-1.
    localparam int DEF_CNT_W    = 10;

    function automatic int axis_total(input int act, input int fp,
                                      input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// -----------------------------------------------------------------------------
// vga_axis
//   One raster axis: a wrapping position counter plus its phase FSM.
//   Used twice by vga_timing, once per pixel (H) and once per line (V).
//
//   Parameters:
//     ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN : phase lengths in counter steps
//     CNT_W                                : counter width (must hold total-1)
//   Ports:
//     clk   in  : pixel clock
//     rst   in  : asynchronous active-high reset (counter 0, phase ACTIVE)
//     adv   in  : advance the counter by one step this clock
//     cnt   out : current counter value, 0..total-1
//     phase out : current phase, always consistent with cnt
//     wrap  out : high when this clock advances cnt from total-1 back to 0
// -----------------------------------------------------------------------------
module vga_axis
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN     = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BP_LEN     = DEF_H_BP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output vga_phase_t       phase,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

    // Counter values at which the next phase begins.
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] B_FRONT = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] B_SYNC  = CNT_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] B_BACK  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    vga_phase_t       phase_q;
    vga_phase_t       phase_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);

    // State register: counter and phase move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Next state: the phase steps when the *next* counter value reaches the
    // start of the following phase, so phase_q always describes cnt_q.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (adv) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
            case (phase_q)
                ACTIVE:  if (cnt_d == B_FRONT) phase_d = FRONT;
                FRONT:   if (cnt_d == B_SYNC)  phase_d = SYNC;
                SYNC:    if (cnt_d == B_BACK)  phase_d = BACK;
                BACK:    if (cnt_d == '0)      phase_d = ACTIVE;
                default:                       phase_d = ACTIVE;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        cnt   = cnt_q;
        phase = phase_q;
        wrap  = adv & at_last;
    end

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for a 640x480@60 display on the ~25 MHz pixel
//   clock. Produces sync, data-enable and raw pixel coordinates; all outputs
//   are registered one clock behind the internal counter/phase state.
//
//   Ports:
//     clk         in  : pixel clock
//     rst         in  : asynchronous active-high reset
//     hsync       out : horizontal sync, active-low
//     vsync       out : vertical sync, active-low
//     de          out : visible-area enable
//     x, y        out : raw H/V counter values (not clamped; gate on de)
//     line_start  out : one-cycle pulse at x==0
//     frame_start out : one-cycle pulse at x==0, y==0
//
//   Build option VGA_TIMING_PIPE_EN: hsync, vsync, de, line_start and
//   frame_start get one extra register stage, so x/y lead them by one clock
//   (for a colour generator with a one-cycle registered lookup).
// -----------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    vga_phase_t       h_phase;
    vga_phase_t       v_phase;
    logic             h_wrap;
    logic             v_wrap_unused;

    vga_axis #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .adv   (1'b1),
        .cnt   (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // Lines advance on the pixel-counter wrap, so V phase changes (and the
    // vsync edges) always coincide with hcnt returning to 0.
    vga_axis #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .adv   (h_wrap),
        .cnt   (v_cnt),
        .phase (v_phase),
        .wrap  (v_wrap_unused)
    );

    logic hsync_p1;
    logic vsync_p1;
    logic de_p1;
    logic line_start_p1;
    logic frame_start_p1;

    // ---- stage p1: decode counter/phase state into registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_p1       <= 1'b1;
            vsync_p1       <= 1'b1;
            de_p1          <= 1'b0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            x              <= '0;
            y              <= '0;
        end else begin
            hsync_p1       <= (h_phase != SYNC);
            vsync_p1       <= (v_phase != SYNC);
            de_p1          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            line_start_p1  <= (h_cnt == '0);
            frame_start_p1 <= (h_cnt == '0) && (v_cnt == '0);
            x              <= h_cnt;
            y              <= v_cnt;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic hsync_p2;
    logic vsync_p2;
    logic de_p2;
    logic line_start_p2;
    logic frame_start_p2;

    // ---- stage p2: control signals delayed one more clock; x/y are not ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_p2       <= 1'b1;
            vsync_p2       <= 1'b1;
            de_p2          <= 1'b0;
            line_start_p2  <= 1'b0;
            frame_start_p2 <= 1'b0;
        end else begin
            hsync_p2       <= hsync_p1;
            vsync_p2       <= vsync_p1;
            de_p2          <= de_p1;
            line_start_p2  <= line_start_p1;
            frame_start_p2 <= frame_start_p1;
        end
    end

    assign hsync       = hsync_p2;
    assign vsync       = vsync_p2;
    assign de          = de_p2;
    assign line_start  = line_start_p2;
    assign frame_start = frame_start_p2;
`else
    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign de          = de_p1;
    assign line_start  = line_start_p1;
    assign frame_start = frame_start_p1;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//   Two instances share clock and reset: one with the default 640x480 timing
//   and one with a tiny raster so full frames and the double wrap are reached
//   quickly. Expected outputs come from a pixel-index model: after n+1 edges
//   out of reset the raster shows pixel n, whose coordinates and sync/enable
//   levels follow from plain arithmetic on the timing parameters.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;

    localparam int B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 4;
    localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

`ifdef VGA_TIMING_PIPE_EN
    localparam int CTL_LAG = 1;
`else
    localparam int CTL_LAG = 0;
`endif

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
    } ctl_t;

    logic       clk;
    logic       rst;

    logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    int tests = 0;
    int fails = 0;
    int n     = -1;   // pixel index currently presented; <0 means reset
    int cyc   = 0;

    int   last_ls_a  = -1;
    int   hs_start_a = -1;
    logic hs_prev_a  = 1'b1;
    int   last_fs_b  = -1;
    int   vs_start_b = -1;
    logic vs_prev_b  = 1'b1;

    vga_timing u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .de          (de_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing #(
        .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .CNT_W    (10)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .de          (de_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t ctl_ref(input int idx, input int ha, input int hf,
                                     input int hs, input int ht, input int va,
                                     input int vf, input int vs, input int vt);
        int px, ln;
        ctl_t c;
        if (idx < 0) begin
            c = '{hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};
            return c;
        end
        px = idx % ht;
        ln = (idx / ht) % vt;
        c.hs = !(px >= ha + hf && px < ha + hf + hs);
        c.vs = !(ln >= va + vf && ln < va + vf + vs);
        c.de = (px < ha) && (ln < va);
        c.ls = (px == 0);
        c.fs = (px == 0) && (ln == 0);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d, pixel %0d)",
                   tag, obs, exp, cyc, n);
        end
    endtask

    task automatic check_all();
        ctl_t ea, eb;
        int   xa, ya, xb, yb;
        ea = ctl_ref(n - CTL_LAG, A_HA, A_HF, A_HS, A_HT, A_VA, A_VF, A_VS, A_VT);
        eb = ctl_ref(n - CTL_LAG, B_HA, B_HF, B_HS, B_HT, B_VA, B_VF, B_VS, B_VT);
        xa = (n < 0) ? 0 : n % A_HT;
        ya = (n < 0) ? 0 : (n / A_HT) % A_VT;
        xb = (n < 0) ? 0 : n % B_HT;
        yb = (n < 0) ? 0 : (n / B_HT) % B_VT;

        chk("a_x",           32'(x_a),     32'(xa));
        chk("a_y",           32'(y_a),     32'(ya));
        chk("a_hsync",       32'(hsync_a), 32'(ea.hs));
        chk("a_vsync",       32'(vsync_a), 32'(ea.vs));
        chk("a_de",          32'(de_a),    32'(ea.de));
        chk("a_line_start",  32'(ls_a),    32'(ea.ls));
        chk("a_frame_start", 32'(fs_a),    32'(ea.fs));
        chk("b_x",           32'(x_b),     32'(xb));
        chk("b_y",           32'(y_b),     32'(yb));
        chk("b_hsync",       32'(hsync_b), 32'(eb.hs));
        chk("b_vsync",       32'(vsync_b), 32'(eb.vs));
        chk("b_de",          32'(de_b),    32'(eb.de));
        chk("b_line_start",  32'(ls_b),    32'(eb.ls));
        chk("b_frame_start", 32'(fs_b),    32'(eb.fs));

        // Interval measurements on the DUT outputs themselves.
        if (rst) begin
            last_ls_a  = -1;
            hs_start_a = -1;
            last_fs_b  = -1;
            vs_start_b = -1;
            hs_prev_a  = 1'b1;
            vs_prev_b  = 1'b1;
        end else begin
            if (ls_a === 1'b1) begin
                if (last_ls_a >= 0) chk("a_line_period", 32'(cyc - last_ls_a), 32'(A_HT));
                last_ls_a = cyc;
            end
            if (hsync_a === 1'b0 && hs_prev_a === 1'b1) hs_start_a = cyc;
            if (hsync_a === 1'b1 && hs_prev_a === 1'b0 && hs_start_a >= 0)
                chk("a_hsync_width", 32'(cyc - hs_start_a), 32'(A_HS));
            hs_prev_a = hsync_a;

            if (fs_b === 1'b1) begin
                if (last_fs_b >= 0) chk("b_frame_period", 32'(cyc - last_fs_b), 32'(B_HT * B_VT));
                last_fs_b = cyc;
            end
            if (vsync_b === 1'b0 && vs_prev_b === 1'b1) vs_start_b = cyc;
            if (vsync_b === 1'b1 && vs_prev_b === 1'b0 && vs_start_b >= 0)
                chk("b_vsync_width", 32'(cyc - vs_start_b), 32'(B_VS * B_HT));
            vs_prev_b = vsync_b;
        end
    endtask

    // One clock: the raster advances on every edge seen with rst low.
    task automatic tick();
        @(posedge clk);
        if (rst) n = -1;
        else     n = n + 1;
        #1;
        cyc++;
        check_all();
    endtask

    // Assert reset between edges and check the asynchronous response at once.
    task automatic reset_pulse(input int edges);
        rst = 1'b1;
        n   = -1;
        #1;
        check_all();
        repeat (edges) tick();
        rst = 1'b0;
    endtask

    initial begin
        int run_len;
        int guard;

        // Power-up reset.
        rst = 1'b1;
        #1;
        check_all();
        repeat (3) tick();
        rst = 1'b0;

        // First edge after release presents pixel (0,0).
        tick();

        // Two-plus lines of the default raster; tiny raster covers many frames.
        repeat (2 * A_HT + 100) tick();

        // Reset held for 3 clocks while the default raster is at x==300.
        guard = 0;
        while ((n % A_HT) != 300 && guard < 2 * A_HT) begin
            tick();
            guard++;
        end
        chk("seek_x300", 32'(n % A_HT), 32'd300);
        reset_pulse(3);
        tick();
        repeat (A_HT + 50) tick();

        // Randomised run lengths, reset phase and reset durations.
        for (int i = 0; i < 10; i++) begin
            run_len = $urandom_range(3000, 20);
            repeat (run_len) tick();
            #($urandom_range(3, 0));
            reset_pulse($urandom_range(4, 1));
            tick();
        end

        // Long tail so the tiny raster wraps (last pixel -> 0,0) repeatedly.
        repeat (4 * B_HT * B_VT) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator that consumes the ~25 MHz pixel clock produced by the VGA PLL. It generates the sync, data-enable and pixel-coordinate outputs for a 640x480@60 display. It sits between the clock block and the game's pixel/colour logic, which draws from `x`/`y` while `de` is high.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CNT_W`, 10, coordinate/counter width; must hold both totals minus 1

Ports:
- `clk` in 1: pixel clock; the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `de` out 1: high while the current pixel is in the visible area.
- `x` out CNT_W: horizontal counter value for the current pixel, 0..H_TOTAL-1.
- `y` out CNT_W: vertical counter value for the current pixel, 0..V_TOTAL-1.
- `line_start` out 1: one-cycle pulse when x==0.
- `frame_start` out 1: one-cycle pulse when x==0 and y==0.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- `hcnt` increments every clock and wraps H_TOTAL-1→0. `vcnt` advances only on the hcnt wrap and wraps V_TOTAL-1→0 on the same edge that hcnt wraps.
- Each axis has a phase FSM with states ACTIVE→FRONT→SYNC→BACK→ACTIVE. A transition occurs when the axis counter hits the phase boundary:
  - H boundaries: 640, 656, 752, 0.
  - V boundaries: 480, 490, 492, 0.
  - The V FSM moves only on H wrap.
- Decode:
  - `hsync`=0 iff H phase is SYNC; `vsync`=0 iff V phase is SYNC.
  - `de`=1 iff both phases are ACTIVE.
- `x`/`y` are raw counter values and are not clamped outside the visible area; consumers gate on `de`.
- Vsync edges align with hcnt==0.
- All outputs are registered from the counter/FSM state.
- No runtime inputs, so there are no simultaneous-event cases beyond the H/V double wrap at (799,524)→(0,0), which must produce frame_start and line_start together.

## Timing
- Reset (async assert, held while `rst`=1):
  - Counters 0; both FSMs ACTIVE.
  - Outputs: `hsync`=1, `vsync`=1, `de`=0, `x`=0, `y`=0, `line_start`=0, `frame_start`=0.
- Output latency is one clock from counter state: the first rising edge after `rst` deasserts presents pixel (0,0) with `de`=1, `frame_start`=1, `line_start`=1.
- Reset mid-frame: outputs go to reset values immediately, asynchronously. The raster restarts at (0,0) on the first edge after release with no partial-line artefact.
- Period: 800 clocks per line, 420000 clocks per frame.
- hsync low for 96 consecutive clocks starting at x=656.
- vsync low for 1600 clocks starting at (x=0, y=490).

## Configuration
- `VGA_TIMING_PIPE_EN` defined:
  - `hsync`, `vsync`, `de`, `line_start`, `frame_start` pass through one extra register stage; `x`/`y` do not.
  - Coordinates therefore lead the control signals by exactly one clock, which suits a colour generator with one-cycle registered lookup.
  - Reset value of the extra stage equals the reset values above.
- Not defined: all outputs are co-timed as described in Timing.

## Structure
- Package `vga_pkg` holds:
  - Phase enum `vga_phase_t` {ACTIVE, FRONT, SYNC, BACK}.
  - Default 640x480 localparams.
  - `CNT_W`.
- Sub-module `vga_axis`, instantiated twice (H and V):
  - Parameters: ACTIVE/FP/SYNC/BP.
  - Inputs: `clk`, `rst`, `adv`.
  - Outputs: `cnt`, `phase`, `wrap`.
  - Wiring: the H instance has `adv`=1; the V instance has `adv` = H `wrap`.
- Top level: sync/de decode and output registers (plus the optional pipe stage).

## Test plan
- Reset release → first edge: x=0, y=0, de=1, frame_start=1, line_start=1, hsync=1, vsync=1.
- Run one line → hsync falls at x=656, rises at x=752; de falls at x=640; next line_start exactly 800 clocks after the previous one.
- Run full frame → vsync low for lines 490–491 only (1600 clocks); de=0 for y≥480; frame_start period = 420000 clocks.
- Wrap at (799,524) → next cycle (0,0) with frame_start and line_start both 1; y never reaches 525.
- Assert `rst` at (300,200) for 3 clocks → outputs at reset values immediately; raster restarts at (0,0) after release.
- With `VGA_TIMING_PIPE_EN`: x==640 observed one clock before de falls; hsync falls one clock after x==656.
